split16to4_r: RTL and testbench

//  Inverse of the sorter merge stage: captures one merged, sorted block of
//  N elements (16 for QAM16, first 4 used for QPSK) and streams it out as
//  M-element beats over a valid/ready interface to the V2V symbol mapper.
//  It sits directly after the 8-to-16 merge output and decouples the wide

---
 rtl/split16to4_r.sv | 149 ++++++++++++++
 tb/tb_split16to4_r.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/split16to4_r.sv
// ---------------------------------------------------------------------------
// split16to4_r
// Captures one merged, sorted block of N elements and streams it out as
// M-element beats over a valid/ready interface. A block is emitted as a
// single beat (QPSK, mode 00) or as N/M beats (QAM16, any other mode). The
// mode is sampled at the moment the block is accepted.
//
// Ports
//  clk        in   rising-edge system clock
//  rst        in   asynchronous active-low reset
//  load       in   one-cycle strobe requesting capture of in_data
//  mode       in   00 = QPSK (1 beat), otherwise QAM16 (N/M beats)
//  in_data    in   merged block, element i at [i*WIDTH +: WIDTH]
//  in_ready   out  a block can be accepted this cycle (combinational)
//  out_data   out  current beat, element j = block element k*M+j
//  out_valid  out  out_data / out_idx / out_last are valid
//  out_ready  in   downstream accepts the current beat
//  out_idx    out  beat number k within the block
//  out_last   out  current beat is the last of the block
//  overrun    out  sticky flag: load seen while in_ready was low
// ---------------------------------------------------------------------------
module split16to4_r #(
    parameter  int WIDTH = 8,
    parameter  int N     = 16,
    parameter  int M     = 4,
    localparam int NB    = N / M,
    localparam int IDXW  = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [1:0]           mode,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic                 in_ready,
    output logic [M*WIDTH-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDXW-1:0]      out_idx,
    output logic                 out_last,
    output logic                 overrun
);

    localparam logic [0:0]      ST_IDLE = 1'b0;
    localparam logic [0:0]      ST_SEND = 1'b1;
    localparam logic [IDXW-1:0] LAST_K  = IDXW'(NB - 1);

    logic [0:0]         state_r,     state_nx_s;
    logic [N*WIDTH-1:0] block_r,     block_nx_s;
    logic               qpsk_r,      qpsk_nx_s;
    logic [IDXW-1:0]    k_r,         k_nx_s;
    logic [M*WIDTH-1:0] out_data_r,  out_data_nx_s;
    logic               out_valid_r, out_valid_nx_s;
    logic               out_last_r,  out_last_nx_s;
    logic               overrun_r,   overrun_nx_s;

    logic               in_ready_s;
    logic               accept_s;
    logic               beat_hs_s;
    logic [IDXW-1:0]    k_inc_s;

    // Select beat k (M consecutive elements) out of a held block.
    function automatic logic [M*WIDTH-1:0] beat_sel(
        input logic [N*WIDTH-1:0] blk,
        input logic [IDXW-1:0]    k
    );
        beat_sel = blk[int'(k)*M*WIDTH +: M*WIDTH];
    endfunction

    // Ready for a new block when empty, or when the last beat leaves this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if (state_r == ST_IDLE) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = out_valid_r & out_last_r & out_ready;
        end
    end

    assign accept_s  = load & in_ready_s;
    assign beat_hs_s = out_valid_r & out_ready;
    assign k_inc_s   = k_r + {{(IDXW-1){1'b0}}, 1'b1};

    // Next-state computation for the block holder and beat sequencer.
    always_comb begin
        state_nx_s     = state_r;
        block_nx_s     = block_r;
        qpsk_nx_s      = qpsk_r;
        k_nx_s         = k_r;
        out_data_nx_s  = out_data_r;
        out_valid_nx_s = out_valid_r;
        out_last_nx_s  = out_last_r;
        overrun_nx_s   = overrun_r | (load & ~in_ready_s);

        if (accept_s) begin
            // Covers both the idle case and a back-to-back load on the last beat.
            state_nx_s     = ST_SEND;
            block_nx_s     = in_data;
            qpsk_nx_s      = (mode == 2'b00);
            k_nx_s         = {IDXW{1'b0}};
            out_data_nx_s  = in_data[M*WIDTH-1:0];
            out_valid_nx_s = 1'b1;
            out_last_nx_s  = (mode == 2'b00) || (LAST_K == {IDXW{1'b0}});
        end else if (beat_hs_s && !out_last_r) begin
            k_nx_s         = k_inc_s;
            out_data_nx_s  = beat_sel(block_r, k_inc_s);
            out_last_nx_s  = qpsk_r || (k_inc_s == LAST_K);
        end else if (beat_hs_s) begin
            state_nx_s     = ST_IDLE;
            k_nx_s         = {IDXW{1'b0}};
            out_data_nx_s  = {(M*WIDTH){1'b0}};
            out_valid_nx_s = 1'b0;
            out_last_nx_s  = 1'b0;
        end else begin
            // No handshake: everything presented downstream stays stable.
            state_nx_s     = state_r;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            block_r     <= {(N*WIDTH){1'b0}};
            qpsk_r      <= 1'b0;
            k_r         <= {IDXW{1'b0}};
            out_data_r  <= {(M*WIDTH){1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            block_r     <= block_nx_s;
            qpsk_r      <= qpsk_nx_s;
            k_r         <= k_nx_s;
            out_data_r  <= out_data_nx_s;
            out_valid_r <= out_valid_nx_s;
            out_last_r  <= out_last_nx_s;
            overrun_r   <= overrun_nx_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_idx   = k_r;
    assign out_last  = out_last_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_split16to4_r.sv
// ---------------------------------------------------------------------------
// tb_split16to4_r
// Self-checking bench for split16to4_r: a directed back-to-back sequence, a
// table of per-cycle vectors (QAM16, QPSK, backpressure, overrun), random
// traffic against a queue-of-beats reference model, and an asynchronous
// reset applied in the middle of a block.
// ---------------------------------------------------------------------------
module tb_split16to4_r;

    localparam logic [127:0] RAMP = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    logic         clk;
    logic         rst;
    logic         load;
    logic [1:0]   mode;
    logic [127:0] in_data;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_idx;
    logic         out_last;
    logic         overrun;

    int n_vec = 0;
    int n_err = 0;

    split16to4_r dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .mode      (mode),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of beats still owed downstream.
    typedef struct {
        logic [31:0] d;
        logic [1:0]  idx;
        logic        last;
    } beat_t;

    beat_t q[$];
    logic  m_ovr = 1'b0;

    // Per-cycle table record: inputs plus the outputs expected before the edge.
    typedef struct {
        logic         load;
        logic [1:0]   mode;
        logic [127:0] din;
        logic         ordy;
        logic         e_valid;
        logic [31:0]  e_data;
        logic [1:0]   e_idx;
        logic         e_last;
        logic         e_inr;
        logic         e_ovr;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [31:0] beat_of(input logic [127:0] d, input int k);
        logic [31:0] r;
        r = 32'h0;
        for (int j = 0; j < 4; j++) r[j*8 +: 8] = d[(k*4 + j)*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs for the coming edge, away from the active edge.
    task automatic setin(input logic l, input logic [1:0] md, input logic [127:0] d, input logic r);
        @(negedge clk);
        load = l; mode = md; in_data = d; out_ready = r;
        #1;
    endtask

    // Compare DUT outputs against the reference model.
    task automatic mcheck(input string tag);
        logic busy;
        busy = (q.size() > 0);
        chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, busy});
        chk({tag, ".data"}, out_data, busy ? q[0].d : 32'h0);
        if (busy) begin
            chk({tag, ".idx"}, {30'b0, out_idx}, {30'b0, q[0].idx});
            chk({tag, ".last"}, {31'b0, out_last}, {31'b0, q[0].last});
        end
        chk({tag, ".in_ready"}, {31'b0, in_ready},
            {31'b0, (q.size() == 0) || (q.size() == 1 && out_ready)});
        chk({tag, ".overrun"}, {31'b0, overrun}, {31'b0, m_ovr});
    endtask

    // Apply the current inputs to the model, then take the clock edge.
    task automatic advance();
        logic rdy;
        int   nb;
        rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
        if (load && !rdy) m_ovr = 1'b1;
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (load && rdy) begin
            nb = (mode == 2'b00) ? 1 : 4;
            for (int k = 0; k < nb; k++)
                q.push_back('{beat_of(in_data, k), 2'(k), (k == nb - 1)});
        end
        @(posedge clk);
    endtask

    task automatic step(input string tag, input logic l, input logic [1:0] md,
                        input logic [127:0] d, input logic r);
        setin(l, md, d, r);
        mcheck(tag);
        advance();
    endtask

    initial begin
        logic [127:0] blk_a, blk_b;

        // Cycle table: QAM16 ramp, QPSK ramp, QAM16 with stall and overrun.
        //            load mode   din             ordy  valid data          idx   last  inr   ovr
        tbl[0]  = '{1'b1, 2'b01, RAMP,           1'b1, 1'b0, 32'h00000000, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 2'b01, RAMP,           1'b1, 1'b1, 32'h03020100, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 2'b00, RAMP,           1'b1, 1'b1, 32'h07060504, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 2'b01, RAMP,           1'b1, 1'b1, 32'h0B0A0908, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 2'b01, RAMP,           1'b1, 1'b1, 32'h0F0E0D0C, 2'd3, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 2'b00, RAMP,           1'b1, 1'b0, 32'h00000000, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 2'b01, RAMP,           1'b1, 1'b1, 32'h03020100, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 2'b10, RAMP,           1'b1, 1'b0, 32'h00000000, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 2'b00, RAMP,           1'b1, 1'b1, 32'h03020100, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 2'b00, RAMP,           1'b0, 1'b1, 32'h07060504, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 2'b00, {128{1'b1}},    1'b0, 1'b1, 32'h07060504, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 2'b00, RAMP,           1'b0, 1'b1, 32'h07060504, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 2'b00, RAMP,           1'b1, 1'b1, 32'h07060504, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 2'b00, RAMP,           1'b1, 1'b1, 32'h0B0A0908, 2'd2, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 2'b00, RAMP,           1'b1, 1'b1, 32'h0F0E0D0C, 2'd3, 1'b1, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 2'b00, RAMP,           1'b1, 1'b0, 32'h00000000, 2'd0, 1'b0, 1'b1, 1'b1};

        rst = 1'b0; load = 1'b0; mode = 2'b00; in_data = 128'h0; out_ready = 1'b0;
        #1;
        chk("reset.valid",    {31'b0, out_valid}, 32'd0);
        chk("reset.data",     out_data,           32'h0);
        chk("reset.idx",      {30'b0, out_idx},   32'd0);
        chk("reset.last",     {31'b0, out_last},  32'd0);
        chk("reset.in_ready", {31'b0, in_ready},  32'd1);
        chk("reset.overrun",  {31'b0, overrun},   32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back: block B loaded on the last beat of block A.
        blk_a = RAMP;
        blk_b = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
        step("b2b.load_a", 1'b1, 2'b01, blk_a, 1'b1);
        step("b2b.a0", 1'b0, 2'b01, 128'h0, 1'b1);
        step("b2b.a1", 1'b0, 2'b01, 128'h0, 1'b1);
        step("b2b.a2", 1'b0, 2'b01, 128'h0, 1'b1);
        setin(1'b1, 2'b01, blk_b, 1'b1);
        mcheck("b2b.a3");
        chk("b2b.in_ready_on_last", {31'b0, in_ready}, 32'd1);
        advance();
        setin(1'b0, 2'b01, 128'h0, 1'b1);
        chk("b2b.no_bubble", {31'b0, out_valid}, 32'd1);
        chk("b2b.b0_data",   out_data, 32'h3C2D1E0F);
        chk("b2b.b0_idx",    {30'b0, out_idx}, 32'd0);
        chk("b2b.overrun",   {31'b0, overrun}, 32'd0);
        mcheck("b2b.b0");
        advance();
        for (int i = 1; i < 5; i++) step("b2b.drain", 1'b0, 2'b01, 128'h0, 1'b1);

        // Table-driven cycles; the model is stepped too so it stays in sync.
        for (int i = 0; i < 16; i++) begin
            setin(tbl[i].load, tbl[i].mode, tbl[i].din, tbl[i].ordy);
            chk($sformatf("tbl%0d.valid", i),    {31'b0, out_valid}, {31'b0, tbl[i].e_valid});
            chk($sformatf("tbl%0d.data", i),     out_data,           tbl[i].e_data);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d.idx", i),  {30'b0, out_idx},   {30'b0, tbl[i].e_idx});
                chk($sformatf("tbl%0d.last", i), {31'b0, out_last},  {31'b0, tbl[i].e_last});
            end
            chk($sformatf("tbl%0d.in_ready", i), {31'b0, in_ready},  {31'b0, tbl[i].e_inr});
            chk($sformatf("tbl%0d.overrun", i),  {31'b0, overrun},   {31'b0, tbl[i].e_ovr});
            advance();
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 ($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)),
                 {$urandom, $urandom, $urandom, $urandom},
                 ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset in the middle of a block.
        for (int i = 0; i < 6; i++) step("pre_rst.drain", 1'b0, 2'b00, 128'h0, 1'b1);
        step("pre_rst.load", 1'b1, 2'b01, RAMP, 1'b0);
        setin(1'b0, 2'b01, 128'h0, 1'b0);
        mcheck("pre_rst.send");
        #1 rst = 1'b0;
        #1;
        chk("midrst.valid",    {31'b0, out_valid}, 32'd0);
        chk("midrst.data",     out_data,           32'h0);
        chk("midrst.in_ready", {31'b0, in_ready},  32'd1);
        chk("midrst.overrun",  {31'b0, overrun},   32'd0);
        q.delete();
        m_ovr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step("post_rst",
                 ($urandom_range(0, 1) == 0),
                 2'($urandom_range(0, 3)),
                 {$urandom, $urandom, $urandom, $urandom},
                 ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
